// File: rtl/alu_pkg.sv
// Shared ALU control codes and the arbiter FSM state type.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_rr_pick.sv
// Two-input round-robin pick: a lone requester wins outright, a tie goes
// to whichever requester was not granted last.
module alu_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic winner,
    output logic valid
);

    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            winner = ~last_grant;
        end else begin
            winner = req1;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between a core and a UART debug requester,
// one operation at a time through IDLE -> EXEC -> RESP.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [2:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] rdata,
    output logic             rzero,
    output logic             busy,
    output logic [2:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic             owner;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             pick_winner;
    logic             pick_valid;

    alu_rr_pick u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operation latch, result register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_q       <= ALU_ADD;
            a_q        <= '0;
            b_q        <= '0;
            rdata      <= '0;
            rzero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner <= pick_winner;
                        op_q  <= pick_winner ? op1 : op0;
                        a_q   <= pick_winner ? a1  : a0;
                        b_q   <= pick_winner ? b1  : b0;
                    end
                end
                EXEC: begin
                    rdata <= alu_result;
                    rzero <= alu_zero;
                end
                RESP:    last_grant <= owner;
                default: ;
            endcase
        end
    end

    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        done0    = 1'b0;
        done1    = 1'b0;
        busy     = (state != IDLE);
        alu_ctrl = ALU_ADD;
        alu_a    = '0;
        alu_b    = '0;
        case (state)
            EXEC: begin
                gnt0     = ~owner;
                gnt1     = owner;
                alu_ctrl = op_q;
                alu_a    = a_q;
                alu_b    = b_q;
            end
            RESP: begin
                done0 = ~owner;
                done1 = owner;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with an external behavioural ALU.
module tb_alu_share_arbiter;

    localparam int W = 32;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [2:0]   op0, op1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         gnt0, gnt1, done0, done1, rzero, busy, alu_zero;
    logic [W-1:0] rdata, alu_a, alu_b, alu_result;
    logic [2:0]   alu_ctrl;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;
    exp_t q0[$];
    exp_t q1[$];
    int   glog[$];
    int   gcyc[$];

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .op0        (op0),
        .a0         (a0),
        .b0         (b0),
        .req1       (req1),
        .op1        (op1),
        .a1         (a1),
        .b1         (b1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .done0      (done0),
        .done1      (done1),
        .rdata      (rdata),
        .rzero      (rzero),
        .busy       (busy),
        .alu_ctrl   (alu_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b101:  return a * b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 1 : 0;
            default: return a ^ b;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_ctrl, alu_a, alu_b);
        alu_zero   = (alu_result == '0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx, input logic r, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (idx == 0) begin
            req0 = r; op0 = op; a0 = a; b0 = b;
        end else begin
            req1 = r; op1 = op; a1 = a; b1 = b;
        end
    endtask

    task automatic set_req(input int idx, input logic r);
        if (idx == 0) req0 = r;
        else          req1 = r;
    endtask

    task automatic push_exp(input int idx, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.op = op;
        e.a  = a;
        e.b  = b;
        e.r  = alu_fn(op, a, b);
        e.z  = (e.r == '0);
        if (idx == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    // mode 0: random ops, random gaps, random post-grant disturbance
    // mode 1: SUB 7,7 back to back
    // mode 2: drop req and scramble operands on grant
    task automatic requester(input int idx, input int n_ops, input int mode);
        for (int k = 0; k < n_ops; k++) begin
            logic [2:0]   op;
            logic [W-1:0] a, b;
            bit           got;
            int           gap;
            gap = (mode == 0) ? int'($urandom_range(6, 0)) : 0;
            if (k > 0) gap = gap + 1;
            repeat (gap) tick();
            if (mode == 1) begin
                op = 3'b110; a = 7; b = 7;
            end else begin
                op = 3'($urandom_range(7, 0));
                a  = $urandom;
                b  = ($urandom_range(3, 0) == 0) ? a : W'($urandom);
            end
            push_exp(idx, op, a, b);
            drive(idx, 1'b1, op, a, b);
            got = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                tick();
                if ((idx == 0 ? gnt0 : gnt1) == 1'b1) begin
                    if (mode == 2 || (mode == 0 && $urandom_range(3, 0) == 0))
                        drive(idx, 1'b0, 3'($urandom_range(7, 0)), $urandom, $urandom);
                    else if (mode == 0 && $urandom_range(3, 0) == 0)
                        drive(idx, 1'b1, 3'($urandom_range(7, 0)), $urandom, $urandom);
                end
                if ((idx == 0 ? done0 : done1) == 1'b1) begin
                    got = 1'b1;
                    set_req(idx, 1'b0);
                end
            end
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("FAIL done_timeout: requester %0d got no done within 40 cycles", idx);
                set_req(idx, 1'b0);
            end
        end
    endtask

    // Spec-level monitor: a request seen in an idle cycle yields a grant next
    // cycle, a grant yields a done next cycle, results come from the queues.
    bit           p_rst = 1'b1, p_busy = 1'b0, p_req0 = 1'b0, p_req1 = 1'b0, p_gnt0 = 1'b0, p_gnt1 = 1'b0;
    int           last_served = 1;
    logic [W-1:0] held_r = '0;
    logic         held_z = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            bit   eg, ed0, ed1;
            int   w;
            exp_t e;
            eg  = !p_rst && !p_busy && (p_req0 || p_req1);
            w   = (p_req0 && p_req1) ? (last_served == 0 ? 1 : 0) : (p_req1 ? 1 : 0);
            ed0 = !p_rst && p_gnt0;
            ed1 = !p_rst && p_gnt1;
            check("gnt_excl",  64'(gnt0 & gnt1), 64'd0);
            check("done_excl", 64'(done0 & done1), 64'd0);
            check("gnt0",  64'(gnt0),  64'(eg && w == 0));
            check("gnt1",  64'(gnt1),  64'(eg && w == 1));
            check("done0", 64'(done0), 64'(ed0));
            check("done1", 64'(done1), 64'(ed1));
            check("busy",  64'(busy),  64'(eg || ed0 || ed1));
            if (gnt0 && q0.size() > 0) begin
                check("alu_ctrl0", 64'(alu_ctrl), 64'(q0[0].op));
                check("alu_a0",    64'(alu_a),    64'(q0[0].a));
                check("alu_b0",    64'(alu_b),    64'(q0[0].b));
            end else if (gnt1 && q1.size() > 0) begin
                check("alu_ctrl1", 64'(alu_ctrl), 64'(q1[0].op));
                check("alu_a1",    64'(alu_a),    64'(q1[0].a));
                check("alu_b1",    64'(alu_b),    64'(q1[0].b));
            end else if (!gnt0 && !gnt1) begin
                check("alu_idle", {alu_ctrl, alu_a, alu_b}, {3'b010, 64'd0});
            end
            if (gnt0) begin glog.push_back(0); gcyc.push_back(cyc); end
            if (gnt1) begin glog.push_back(1); gcyc.push_back(cyc); end
            if (done0 || done1) begin
                if ((done0 && q0.size() == 0) || (done1 && q1.size() == 0)) begin
                    check("done_unexpected", 64'd1, 64'd0);
                end else begin
                    e = done1 ? q1.pop_front() : q0.pop_front();
                    check("rdata", 64'(rdata), 64'(e.r));
                    check("rzero", 64'(rzero), 64'(e.z));
                    held_r      = e.r;
                    held_z      = e.z;
                    last_served = done1 ? 1 : 0;
                end
            end else begin
                check("rdata_hold", 64'(rdata), 64'(held_r));
                check("rzero_hold", 64'(rzero), 64'(held_z));
            end
        end
        p_busy = busy; p_req0 = req0; p_req1 = req1; p_gnt0 = gnt0; p_gnt1 = gnt1; p_rst = rst;
        if (rst) begin
            q0.delete();
            q1.delete();
            held_r      = '0;
            held_z      = 1'b0;
            last_served = 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 3'b000, '0, '0);
        drive(1, 1'b0, 3'b000, '0, '0);
        tick();
        mon_en = 1'b1;
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_rzero", 64'(rzero), 64'd0);
        check("rst_pulses", {gnt0, gnt1, done0, done1}, 64'd0);

        // ADD 5+3 on requester 0
        push_exp(0, 3'b010, 5, 3);
        drive(0, 1'b1, 3'b010, 5, 3);
        tick();
        check("add_gnt0",  64'(gnt0),  64'd1);
        check("add_alu_a", 64'(alu_a), 64'd5);
        tick();
        check("add_done0", 64'(done0), 64'd1);
        check("add_rdata", 64'(rdata), 64'd8);
        check("add_rzero", 64'(rzero), 64'd0);
        set_req(0, 1'b0);
        tick();

        // Both requesters from the first cycle after reset, SUB 7,7 held
        rst = 1'b1;
        tick();
        rst = 1'b0;
        glog.delete();
        gcyc.delete();
        fork
            requester(0, 4, 1);
            requester(1, 4, 1);
        join
        if (glog.size() >= 4) begin
            check("rr_g0", 64'(glog[0]), 64'd0);
            check("rr_g1", 64'(glog[1]), 64'd1);
            check("rr_g2", 64'(glog[2]), 64'd0);
            check("rr_g3", 64'(glog[3]), 64'd1);
            check("rr_gap", 64'(gcyc[1] - gcyc[0]), 64'd3);
        end else begin
            check("rr_gnt_count", 64'(glog.size()), 64'd8);
        end
        repeat (2) tick();

        // Requester 1 drops req and scrambles operands after grant
        requester(1, 1, 2);
        repeat (2) tick();

        // Reset while in EXEC
        push_exp(0, 3'b001, 32'h0f0, 32'h00f);
        push_exp(1, 3'b110, 9, 4);
        drive(0, 1'b1, 3'b001, 32'h0f0, 32'h00f);
        drive(1, 1'b1, 3'b110, 9, 4);
        tick();
        check("rx_busy_exec", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rx_busy",  64'(busy),  64'd0);
        check("rx_rdata", 64'(rdata), 64'd0);
        check("rx_done",  {done0, done1}, 64'd0);
        push_exp(0, 3'b001, 32'h0f0, 32'h00f);
        push_exp(1, 3'b110, 9, 4);
        tick();
        check("rx_gnt0", 64'(gnt0), 64'd1);
        for (int t = 0; t < 10 && (req0 || req1); t++) begin
            tick();
            if (done0) set_req(0, 1'b0);
            if (done1) set_req(1, 1'b0);
        end
        check("rx_drained", {req0, req1}, 64'd0);
        repeat (2) tick();

        // Random traffic from both requesters
        fork
            requester(0, 150, 0);
            requester(1, 150, 0);
        join
        repeat (4) tick();
        check("q_empty", 64'(q0.size() + q1.size()), 64'd0);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
